// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//
// Splits one time-division-multiplexed serial bit stream back into CHANNELS
// parallel words of WIDTH bits each. A sync marker, high with the first bit
// of a frame, aligns the frame. A completed frame is published as a whole,
// together with a single-cycle valid pulse.
//
// Stream order: channel 0 first, then channel 1, and so on. Within a channel
// the bits arrive MSB first. The first bit of a frame therefore ends up in
// ch_data[WIDTH-1].
//
// Ports
//   clock      in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   din        in   serial data bit
//   enable     in   bit strobe; din/sync only sampled when high
//   sync       in   frame marker, high with the first bit of a frame
//   clear_err  in   clears frame_err (an error on the same edge wins)
//   ch_data    out  last complete frame, channel i at [(i+1)*WIDTH-1 : i*WIDTH]
//   ch_valid   out  one-cycle pulse when ch_data updates
//   locked     out  high while receiving a frame or expecting the next sync
//   frame_err  out  sticky framing error flag
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      enable,
    input  logic                      sync,
    input  logic                      clear_err,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic                      ch_valid,
    output logic                      locked,
    output logic                      frame_err
);

    localparam int FRAME_BITS = CHANNELS * WIDTH;
    localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV   = 2'd1,
        EXPECT = 2'd2
    } state_t;

    state_t                    state_q,    state_d;
    logic [CNT_W-1:0]          bitCnt_q,   bitCnt_d;
    logic [FRAME_BITS-2:0]     shiftReg_q, shiftReg_d;
    logic [FRAME_BITS-1:0]     data_q,     data_d;
    logic                      valid_q,    valid_d;
    logic                      err_q,      err_d;

    // Every bit received so far, with the current din appended as the
    // newest bit. The oldest bit sits at the MSB. On the last bit of a frame
    // this vector holds the whole frame.
    logic [FRAME_BITS-1:0]     shifted;

    // The shift register stores the stream in arrival order, with the oldest
    // bit at the MSB. The published layout puts channel 0 in the low word, and
    // each word is MSB-first. Stream bit n (n = c*WIDTH + k) therefore goes to
    // ch_data[c*WIDTH + WIDTH-1-k]. This function is only a re-wiring.
    function automatic logic [FRAME_BITS-1:0] unpackFrame(
        input logic [FRAME_BITS-1:0] stream
    );
        logic [FRAME_BITS-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < WIDTH; k++) begin
                r[c*WIDTH + WIDTH-1-k] = stream[FRAME_BITS-1 - (c*WIDTH + k)];
            end
        end
        return r;
    endfunction

    assign shifted = {shiftReg_q, din};

    // State, counter, shift register and published outputs. A reset discards
    // any partial frame, so the first frame after reset needs a fresh sync.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shiftReg_q <= shiftReg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. Everything holds when enable is low, except the valid
    // pulse, which always drops after one cycle. clear_err acts on every edge.
    // An error event on the same edge is applied afterwards, so the error wins.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shiftReg_d = shiftReg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = clear_err ? 1'b0 : err_q;

        if (enable) begin
            unique case (state_q)
                HUNT: begin
                    // Bits without sync are dropped silently while hunting.
                    if (sync) begin
                        shiftReg_d    = '0;
                        shiftReg_d[0] = din;
                        bitCnt_d      = CNT_W'(1);
                        state_d       = RECV;
                    end
                end

                RECV: begin
                    if (sync) begin
                        // A sync in mid-frame restarts alignment on this bit.
                        // The partial frame is abandoned, so ch_data stays as it was.
                        err_d         = 1'b1;
                        shiftReg_d    = '0;
                        shiftReg_d[0] = din;
                        bitCnt_d      = CNT_W'(1);
                    end else if (bitCnt_q == LAST_BIT) begin
                        data_d     = unpackFrame(shifted);
                        valid_d    = 1'b1;
                        shiftReg_d = shifted[FRAME_BITS-2:0];
                        bitCnt_d   = '0;
                        state_d    = EXPECT;
                    end else begin
                        shiftReg_d = shifted[FRAME_BITS-2:0];
                        bitCnt_d   = bitCnt_q + CNT_W'(1);
                    end
                end

                EXPECT: begin
                    if (sync) begin
                        shiftReg_d    = '0;
                        shiftReg_d[0] = din;
                        bitCnt_d      = CNT_W'(1);
                        state_d       = RECV;
                    end else begin
                        // The next frame did not begin on time, so alignment is lost.
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end

                default: begin
                    state_d  = HUNT;
                    bitCnt_d = '0;
                end
            endcase
        end
    end

    assign ch_data   = data_q;
    assign ch_valid  = valid_q;
    assign frame_err = err_q;
    assign locked    = (state_q == RECV) || (state_q == EXPECT);

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the board's select-based multiplexing. It takes one time-division-multiplexed serial bit stream and splits it back into CHANNELS parallel channel words of WIDTH bits each.
- Frame alignment comes from a sync marker. A complete frame is published atomically with a one-cycle valid pulse.
- Sits between a serial link or pin and the LEDR/HEX display logic of a lab top level.

Parameters:
- CHANNELS, 4: number of channels per frame.
- WIDTH, 8: bits per channel word.
- FRAME_BITS, CHANNELS*WIDTH: derived, not overridden. Must be at least 2.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- enable  in  1  bit strobe; din and sync are sampled only on edges where enable=1.
- sync  in  1  frame marker, high with the first bit of a frame.
- clear_err  in  1  clears frame_err.
- ch_data  out  CHANNELS*WIDTH  last complete frame. Channel i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
- ch_valid  out  1  one-cycle pulse when ch_data updates.
- locked  out  1  high when the state is RECV or EXPECT.
- frame_err  out  1  sticky framing error flag.

Behaviour:
- Reset (async, active-high):
  - state=HUNT; bit counter=0; shift register=0.
  - ch_data=0, ch_valid=0, locked=0, frame_err=0.
  - A partial frame in progress is discarded. The first frame after reset release needs a fresh sync.
- Stream order:
  - Channel 0 is transmitted first, then channel 1, and so on.
  - Within a channel, bits are MSB-first. The first bit of a frame lands in ch_data[WIDTH-1].
- Edges with enable=0 change nothing except ch_valid, which returns to 0. Gaps in enable of any length are allowed mid-frame.
- States (all transitions occur on edges with enable=1):
  - HUNT: sync=1 captures din as frame bit 0, counter=1, go to RECV. sync=0 discards the bit and stays in HUNT; no error.
  - RECV, sync=0: capture din as bit at counter position, counter+1.
  - RECV, sync=1 (sync arrives mid-frame): set frame_err, discard the partial frame, capture din as bit 0, counter=1, stay in RECV.
  - RECV, last bit (counter=FRAME_BITS-1, sync=0): capture the bit and load ch_data with the full frame on that same edge. ch_valid=1 for exactly the next cycle. Counter=0, go to EXPECT.
  - EXPECT, sync=1: start a new frame exactly as in HUNT, go to RECV.
  - EXPECT, sync=0: set frame_err, discard the bit, go to HUNT.
- Latency: ch_data and ch_valid are visible in the cycle after the edge that samples the last bit.
- ch_data holds its value until the next complete frame. Partial or aborted frames never alter it.
- Back-to-back frames (enable held high, sync every FRAME_BITS bits) produce one ch_valid pulse per frame with no gaps or errors.
- frame_err:
  - Sticky; cleared by clear_err=1 on any edge, whether or not enable=1.
  - If an error event and clear_err occur on the same edge, the error wins and frame_err stays 1.
- Counter width is ceil(log2(FRAME_BITS)). The counter never wraps past FRAME_BITS-1.

Test Plan:
- Aligned frame (defaults): reset, then with enable=1 send sync+0xA5, 0x3C, 0xFF, 0x01 MSB-first over 32 bits. Expect ch_data=32'h01FF3CA5, a single 1-cycle ch_valid pulse on the cycle after bit 31, and locked=1.
- Enable gaps: same frame with enable=0 for 3 cycles after every 5th bit. Expect identical ch_data, one ch_valid, frame_err=0.
- Early sync: after 12 bits of a frame, assert sync with a new frame 0x11,0x22,0x33,0x44. Expect frame_err=1 and ch_data=32'h44332211 from the new frame only; the old ch_data is held until then.
- Missing sync: complete a frame, then send a bit with sync=0. Expect frame_err=1 and locked=0 (HUNT). Further non-sync bits do not change ch_data or ch_valid.
- clear_err priority: assert clear_err on the same edge as a missing-sync error, so frame_err remains 1. Assert clear_err alone next cycle, so frame_err=0.
- Reset mid-frame: assert reset asynchronously after 20 bits. All outputs go to 0 immediately without a clock edge. A subsequent full frame decodes correctly.
